// File: rtl/stream_out_pkg.sv
// Shared types for the CPU output stream block.
// Tags, register offsets and STATUS layout.
package stream_out_pkg;

  typedef enum logic [2:0] {
    TAG_BYTE   = 3'd0,
    TAG_ELEM   = 3'd1,
    TAG_ENDROW = 3'd2,
    TAG_ENDMAT = 3'd3,
    TAG_POS    = 3'd4
  } tag_e;

  typedef struct packed {
    tag_e        tag;
    logic [31:0] data;
  } ev_t;

  localparam int EV_W = $bits(ev_t);

  localparam logic [4:0] OFF_BYTE   = 5'h00;
  localparam logic [4:0] OFF_ELEM   = 5'h04;
  localparam logic [4:0] OFF_ENDROW = 5'h08;
  localparam logic [4:0] OFF_ENDMAT = 5'h0C;
  localparam logic [4:0] OFF_POS    = 5'h10;
  localparam logic [4:0] OFF_STATUS = 5'h14;

  localparam int ST_FULL  = 9;
  localparam int ST_EMPTY = 8;

  // Level is at most 256 entries; clamp into the 8-bit field
  function automatic logic [31:0] mk_status(
    input logic       full,
    input logic       empty,
    input logic [8:0] level
  );
    logic [31:0] s;
    s = '0;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[7:0]      = level[8] ? 8'hFF : level[7:0];
    return s;
  endfunction

endpackage

// File: rtl/stream_out_mmio_if.sv
// Bus and output-stream bundle for stream_out_mmio.
// slave = the block itself, master = CPU/host side.
interface stream_out_mmio_if;

  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        out_ready;
  logic        out_byte_en;
  logic [7:0]  out_byte;
  logic        out_matrix_en;
  logic [31:0] out_matrix;
  logic        out_matrix_end_row;
  logic        out_matrix_end;
  logic        out_matrix_position_en;
  logic [7:0]  out_matrix_position;

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata,
    input  out_ready,
    output out_byte_en,
    output out_byte,
    output out_matrix_en,
    output out_matrix,
    output out_matrix_end_row,
    output out_matrix_end,
    output out_matrix_position_en,
    output out_matrix_position
  );

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata,
    output out_ready,
    input  out_byte_en,
    input  out_byte,
    input  out_matrix_en,
    input  out_matrix,
    input  out_matrix_end_row,
    input  out_matrix_end,
    input  out_matrix_position_en,
    input  out_matrix_position
  );

endinterface

// File: rtl/stream_sync_fifo.sv
// Synchronous FIFO with level count.
// DEPTH must be a power of two so pointers wrap for free.
module stream_sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/stream_out_mmio.sv
// PicoRV32 MMIO window feeding a tagged event FIFO that drains
// one event per cycle as single-cycle output pulses.
module stream_out_mmio
  import stream_out_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              resetn,
  stream_out_mmio_if.slave  bus
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          w_hit;
  logic [4:0]    w_off;
  logic          w_wr;
  logic          w_tagged;
  ev_t           w_ev;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;
  logic [8:0]    w_lvl9;
  logic [31:0]   w_status;
  ev_t           w_head;

  logic          r_ready;
  logic [31:0]   r_rdata;
  logic          r_byte_en;
  logic [7:0]    r_byte;
  logic          r_mat_en;
  logic [31:0]   r_mat;
  logic          r_end_row;
  logic          r_end;
  logic          r_pos_en;
  logic [7:0]    r_pos;

  assign w_hit = bus.mem_valid &&
                 (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
  assign w_off = bus.mem_addr[4:0];
  assign w_wr  = |bus.mem_wstrb;

  always_comb begin
    w_tagged    = 1'b1;
    w_ev.tag    = TAG_BYTE;
    w_ev.data   = '0;
    unique case (w_off)
      OFF_BYTE: begin
        w_ev.data = {24'b0, bus.mem_wdata[7:0]};
      end
      OFF_ELEM: begin
        w_ev.tag  = TAG_ELEM;
        w_ev.data = bus.mem_wdata;
      end
      OFF_ENDROW: w_ev.tag = TAG_ENDROW;
      OFF_ENDMAT: w_ev.tag = TAG_ENDMAT;
      OFF_POS: begin
        w_ev.tag  = TAG_POS;
        w_ev.data = {24'b0, bus.mem_wdata[7:0]};
      end
      default: w_tagged = 1'b0;
    endcase
  end

  // r_ready guard keeps a held request from being taken twice
  assign w_accept = w_hit && !r_ready &&
                    !(w_wr && w_tagged && w_full);
  assign w_push   = w_accept && w_wr && w_tagged;
  assign w_pop    = !w_empty && bus.out_ready;

  assign w_lvl9   = 9'(w_level);
  assign w_status = mk_status(w_full, w_empty, w_lvl9);

  stream_sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_wdata (w_ev),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_accept;
      if (w_accept && !w_wr && w_off == OFF_STATUS)
        r_rdata <= w_status;
      else
        r_rdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_byte_en <= 1'b0;
      r_byte    <= '0;
      r_mat_en  <= 1'b0;
      r_mat     <= '0;
      r_end_row <= 1'b0;
      r_end     <= 1'b0;
      r_pos_en  <= 1'b0;
      r_pos     <= '0;
    end else begin
      r_byte_en <= 1'b0;
      r_byte    <= '0;
      r_mat_en  <= 1'b0;
      r_mat     <= '0;
      r_end_row <= 1'b0;
      r_end     <= 1'b0;
      r_pos_en  <= 1'b0;
      r_pos     <= '0;
      if (w_pop) begin
        unique case (w_head.tag)
          TAG_BYTE: begin
            r_byte_en <= 1'b1;
            r_byte    <= w_head.data[7:0];
          end
          TAG_ELEM: begin
            r_mat_en <= 1'b1;
            r_mat    <= w_head.data;
          end
          TAG_ENDROW: r_end_row <= 1'b1;
          TAG_ENDMAT: r_end     <= 1'b1;
          TAG_POS: begin
            r_pos_en <= 1'b1;
            r_pos    <= w_head.data[7:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_ready              = r_ready;
  assign bus.mem_rdata              = r_rdata;
  assign bus.out_byte_en            = r_byte_en;
  assign bus.out_byte               = r_byte;
  assign bus.out_matrix_en          = r_mat_en;
  assign bus.out_matrix             = r_mat;
  assign bus.out_matrix_end_row     = r_end_row;
  assign bus.out_matrix_end         = r_end;
  assign bus.out_matrix_position_en = r_pos_en;
  assign bus.out_matrix_position    = r_pos;

endmodule
